dram_cmd_sequencer: RTL and testbench

//  Single-bank DRAM command sequencer. Accepts one read/write request at a time and issues ACT/RD/WR/PRE/REF.

---
 rtl/dram_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_dram_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_sequencer.sv
// Single-bank DRAM command sequencer: one request at a time, ACT/RD/WR/PRE/REF paced by timing done flags.
// Build option DRAM_OPEN_PAGE_EN selects the open-page policy; left undefined the sequencer is closed-page.
module dram_cmd_sequencer #(
  parameter int ROW_W = 16,
  parameter int COL_W = 10
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic             tACT_done,
  input  logic             tRD_done,
  input  logic             tWR_done,
  input  logic             tPRE_done,
  input  logic             tREF_done,
  input  logic             rf_req,
  output logic [2:0]       cmd,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic             resp_done,
  output logic             row_open
);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [3:0] {
    sIdle,
    sAct,
    sActW,
    sRw,
    sRwW,
    sPre,
    sPreW,
    sRef,
    sRefW
  } stateT;

  stateT            stateReg;
  logic             readyReg;
  logic             respReg;
  logic             rowOpenReg;
  logic             pendReg;
  logic             reqWriteReg;
  logic [2:0]       cmdReg;
  logic [ROW_W-1:0] cmdRowReg;
  logic [ROW_W-1:0] reqRowReg;
  logic [COL_W-1:0] cmdColReg;
  logic [COL_W-1:0] reqColReg;
  logic             accessDone;

`ifdef DRAM_OPEN_PAGE_EN
  logic [ROW_W-1:0] openRowReg;
  logic [ROW_W-1:0] rowMatch;
  logic             rowHit;

  // Incoming row compared bit-by-bit against the row left open by the previous access
  for (genvar gi = 0; gi < ROW_W; gi++) begin : g_rowMatch
    assign rowMatch[gi] = ~(req_row[gi] ^ openRowReg[gi]);
  end
  assign rowHit = &rowMatch;
`endif

  assign accessDone = reqWriteReg ? tWR_done : tRD_done;

  // Refresh must win over a request presented in the same idle cycle
  assign req_ready = readyReg & ~rf_req;
  assign cmd       = cmdReg;
  assign cmd_row   = cmdRowReg;
  assign cmd_col   = cmdColReg;
  assign resp_done = respReg;
  assign row_open  = rowOpenReg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stateReg    <= sIdle;
      cmdReg      <= CMD_NOP;
      cmdRowReg   <= '0;
      cmdColReg   <= '0;
      respReg     <= 1'b0;
      rowOpenReg  <= 1'b0;
      readyReg    <= 1'b0;
      pendReg     <= 1'b0;
      reqWriteReg <= 1'b0;
      reqRowReg   <= '0;
      reqColReg   <= '0;
`ifdef DRAM_OPEN_PAGE_EN
      openRowReg  <= '0;
`endif
    end else begin
      cmdReg   <= CMD_NOP;
      respReg  <= 1'b0;
      readyReg <= 1'b0;
      case (stateReg)
        sIdle: begin
          if (rf_req) begin
            if (rowOpenReg) begin
              stateReg   <= sPre;
              cmdReg     <= CMD_PRE;
              rowOpenReg <= 1'b0;
            end else begin
              stateReg <= sRef;
              cmdReg   <= CMD_REF;
            end
          end else if (req_valid && readyReg) begin
            pendReg     <= 1'b1;
            reqWriteReg <= req_write;
            reqRowReg   <= req_row;
            reqColReg   <= req_col;
            if (!rowOpenReg) begin
              stateReg   <= sAct;
              cmdReg     <= CMD_ACT;
              cmdRowReg  <= req_row;
              rowOpenReg <= 1'b1;
`ifdef DRAM_OPEN_PAGE_EN
              openRowReg <= req_row;
`endif
            end
`ifdef DRAM_OPEN_PAGE_EN
            else if (rowHit) begin
              stateReg  <= sRw;
              cmdReg    <= req_write ? CMD_WR : CMD_RD;
              cmdColReg <= req_col;
            end
`endif
            else begin
              // Row miss: close the open row first, the ACT follows from PRE_W
              stateReg   <= sPre;
              cmdReg     <= CMD_PRE;
              rowOpenReg <= 1'b0;
            end
          end else begin
            readyReg <= 1'b1;
          end
        end

        sAct: stateReg <= sActW;

        sActW: begin
          if (tACT_done) begin
            stateReg  <= sRw;
            cmdReg    <= reqWriteReg ? CMD_WR : CMD_RD;
            cmdColReg <= reqColReg;
          end
        end

        sRw: stateReg <= sRwW;

        sRwW: begin
          if (accessDone) begin
            respReg <= 1'b1;
            pendReg <= 1'b0;
`ifdef DRAM_OPEN_PAGE_EN
            if (rf_req) begin
              stateReg   <= sPre;
              cmdReg     <= CMD_PRE;
              rowOpenReg <= 1'b0;
            end else begin
              stateReg <= sIdle;
              readyReg <= 1'b1;
            end
`else
            stateReg   <= sPre;
            cmdReg     <= CMD_PRE;
            rowOpenReg <= 1'b0;
`endif
          end
        end

        sPre: stateReg <= sPreW;

        sPreW: begin
          if (tPRE_done) begin
            if (rf_req) begin
              stateReg <= sRef;
              cmdReg   <= CMD_REF;
            end else if (pendReg) begin
              stateReg   <= sAct;
              cmdReg     <= CMD_ACT;
              cmdRowReg  <= reqRowReg;
              rowOpenReg <= 1'b1;
`ifdef DRAM_OPEN_PAGE_EN
              openRowReg <= reqRowReg;
`endif
            end else begin
              stateReg <= sIdle;
              readyReg <= 1'b1;
            end
          end
        end

        sRef: stateReg <= sRefW;

        sRefW: begin
          if (tREF_done) begin
            if (pendReg) begin
              stateReg   <= sAct;
              cmdReg     <= CMD_ACT;
              cmdRowReg  <= reqRowReg;
              rowOpenReg <= 1'b1;
`ifdef DRAM_OPEN_PAGE_EN
              openRowReg <= reqRowReg;
`endif
            end else begin
              stateReg <= sIdle;
              readyReg <= 1'b1;
            end
          end
        end

        default: stateReg <= sIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Bench for dram_cmd_sequencer: acts as timing controller with random done delays and noise,
// and compares the observed command/response stream against a transaction-level policy model.
module tb_dram_cmd_sequencer;
  localparam int ROW_W = 16;
  localparam int COL_W = 10;
`ifdef DRAM_OPEN_PAGE_EN
  localparam bit OPEN_PAGE = 1'b1;
`else
  localparam bit OPEN_PAGE = 1'b0;
`endif
  localparam int EV_ACT  = 1;
  localparam int EV_RD   = 2;
  localparam int EV_WR   = 3;
  localparam int EV_PRE  = 4;
  localparam int EV_REF  = 5;
  localparam int EV_DONE = 8;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [ROW_W-1:0] req_row = '0;
  logic [COL_W-1:0] req_col = '0;
  logic             tACT_done = 1'b0;
  logic             tRD_done = 1'b0;
  logic             tWR_done = 1'b0;
  logic             tPRE_done = 1'b0;
  logic             tREF_done = 1'b0;
  logic             rf_req = 1'b0;
  logic [2:0]       cmd;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic             resp_done;
  logic             row_open;

  always #5 CLK = ~CLK;

  dram_cmd_sequencer #(.ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_row(req_row), .req_col(req_col),
    .tACT_done(tACT_done), .tRD_done(tRD_done), .tWR_done(tWR_done),
    .tPRE_done(tPRE_done), .tREF_done(tREF_done), .rf_req(rf_req),
    .cmd(cmd), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .resp_done(resp_done), .row_open(row_open)
  );

  int checks = 0;
  int fails = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input int code, input logic [27:0] payload);
    logic [31:0] c;
    c = code;
    return {c[3:0], payload};
  endfunction

  // Observed events (commands and response pulses) in the order they appear
  logic [31:0] evQ[$];
  int curTxn = 0;
  int preRefTxn = -1;
  int midArmTxn = -1;

  // Monitor plus timing-controller model: each command arms its own done flag after a random delay;
  // all other flags carry random noise that the sequencer must ignore.
  initial begin
    int preDone = -1;
    int midDone = -1;
    int active = 0;
    int waitK = 0;
    int dly = 0;
    logic [31:0] noise;
    forever begin
      @(negedge CLK);
      if (resp_done === 1'b1) evQ.push_back(ev(EV_DONE, 28'd0));
      if (preRefTxn == curTxn && preDone != curTxn) begin
        rf_req = 1'b1;
        preDone = curTxn;
      end
      if (cmd !== 3'd0 && !$isunknown(cmd)) begin
        case (cmd)
          3'd1:       evQ.push_back(ev(EV_ACT, 28'(cmd_row)));
          3'd2, 3'd3: evQ.push_back(ev(int'(cmd), 28'(cmd_col)));
          default:    evQ.push_back(ev(int'(cmd), 28'd0));
        endcase
        if (midArmTxn == curTxn && midDone != curTxn) begin
          rf_req = 1'b1;
          midDone = curTxn;
        end
        if (cmd == 3'd5) rf_req = 1'b0;
        active = int'(cmd);
        waitK = 0;
        dly = $urandom_range(0, 4);
      end
      noise = $urandom;
      tACT_done = noise[0];
      tRD_done  = noise[1];
      tWR_done  = noise[2];
      tPRE_done = noise[3];
      tREF_done = noise[4];
      if (cmd === 3'd0 && active != 0) begin
        case (active)
          EV_ACT:  tACT_done = (waitK == dly);
          EV_RD:   tRD_done  = (waitK == dly);
          EV_WR:   tWR_done  = (waitK == dly);
          EV_PRE:  tPRE_done = (waitK == dly);
          default: tREF_done = (waitK == dly);
        endcase
        if (waitK == dly) active = 0;
        waitK++;
      end
    end
  end

  // Policy model: which row is open, and the command stream each request should produce
  logic [31:0]      expQ[$];
  bit               mRowOpen = 1'b0;
  logic [ROW_W-1:0] mOpenRow = '0;

  task automatic buildExp(input bit w, input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                          input bit pre, input bit mid);
    bit firstPre;
    firstPre = 1'b0;
    expQ.delete();
    if (pre) begin
      if (mRowOpen) expQ.push_back(ev(EV_PRE, 28'd0));
      expQ.push_back(ev(EV_REF, 28'd0));
      mRowOpen = 1'b0;
    end
    if (!mRowOpen) begin
      expQ.push_back(ev(EV_ACT, 28'(row)));
    end else if (!(OPEN_PAGE && mOpenRow == row)) begin
      expQ.push_back(ev(EV_PRE, 28'd0));
      if (mid) expQ.push_back(ev(EV_REF, 28'd0));
      expQ.push_back(ev(EV_ACT, 28'(row)));
      firstPre = 1'b1;
    end
    expQ.push_back(ev(w ? EV_WR : EV_RD, 28'(col)));
    expQ.push_back(ev(EV_DONE, 28'd0));
    if (mid && !firstPre) begin
      expQ.push_back(ev(EV_PRE, 28'd0));
      expQ.push_back(ev(EV_REF, 28'd0));
      mRowOpen = 1'b0;
    end else if (!OPEN_PAGE) begin
      expQ.push_back(ev(EV_PRE, 28'd0));
      mRowOpen = 1'b0;
    end else begin
      mRowOpen = 1'b1;
      mOpenRow = row;
    end
  endtask

  task automatic runTxn(input bit w, input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                        input bit pre, input bit mid, input bit rst);
    int base;
    int n;
    int cut;
    string name;
    logic [31:0] got;
    @(negedge CLK); #1;
    curTxn++;
    name = $sformatf("txn%0d", curTxn);
    base = evQ.size();
    preRefTxn = pre ? curTxn : -1;
    midArmTxn = mid ? curTxn : -1;
    buildExp(w, row, col, pre, mid);
    if (rst) begin
      cut = 0;
      for (int i = 0; i < expQ.size(); i++) begin
        if (expQ[i][31:28] == 4'd2 || expQ[i][31:28] == 4'd3) begin
          cut = i;
          break;
        end
      end
      while (expQ.size() > cut + 1) void'(expQ.pop_back());
      mRowOpen = 1'b0;
    end
    if (pre) begin
      @(negedge CLK); #1;
    end
    req_write = w;
    req_row   = row;
    req_col   = col;
    req_valid = 1'b1;
    if (pre) checkVal({name, " ready_while_refresh"}, 32'(req_ready), 32'd0);
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin
      @(negedge CLK); #1;
      n++;
    end
    checkVal({name, " accepted"}, 32'(n < 300), 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_row   = ROW_W'($urandom);
    req_col   = COL_W'($urandom);

    if (rst) begin
      n = 0;
      while ((evQ.size() - base) < expQ.size() && n < 300) begin
        @(negedge CLK); #1;
        n++;
      end
      @(negedge CLK); #1;
      nRST = 1'b0;
      @(negedge CLK); #1;
      checkVal({name, " rst_cmd"}, 32'(cmd), 32'd0);
      checkVal({name, " rst_row_open"}, 32'(row_open), 32'd0);
      checkVal({name, " rst_resp_done"}, 32'(resp_done), 32'd0);
      checkVal({name, " rst_req_ready"}, 32'(req_ready), 32'd0);
      checkVal({name, " rst_cmd_row"}, 32'(cmd_row), 32'd0);
      checkVal({name, " rst_cmd_col"}, 32'(cmd_col), 32'd0);
      repeat (5) @(negedge CLK);
      #1;
      nRST = 1'b1;
    end

    n = 0;
    while (!((evQ.size() - base) >= expQ.size() && req_ready === 1'b1) && n < 300) begin
      @(negedge CLK); #1;
      n++;
    end
    checkVal({name, " finished"}, 32'(n < 300), 32'd1);
    repeat (3) @(negedge CLK);
    #1;
    checkVal({name, " event_count"}, 32'(evQ.size() - base), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      got = (base + i < evQ.size()) ? evQ[base + i] : 32'hFFFF_FFFF;
      checkVal($sformatf("%s event%0d", name, i), got, expQ[i]);
    end
    checkVal({name, " row_open"}, 32'(row_open), 32'(mRowOpen));
    $display("%s: %s row=0x%h col=0x%h pre_ref=%0d mid_ref=%0d reset=%0d events=%0d",
             name, w ? "WR" : "RD", row, col, pre, mid, rst, evQ.size() - base);
  endtask

  function automatic logic [ROW_W-1:0] pickRow();
    case ($urandom_range(0, 3))
      0:       return ROW_W'(5);
      1:       return ROW_W'(9);
      default: return ROW_W'($urandom);
    endcase
  endfunction

  initial begin
    bit w;
    bit pre;
    bit mid;
    bit rst;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checkVal("reset cmd", 32'(cmd), 32'd0);
    checkVal("reset cmd_row", 32'(cmd_row), 32'd0);
    checkVal("reset cmd_col", 32'(cmd_col), 32'd0);
    checkVal("reset resp_done", 32'(resp_done), 32'd0);
    checkVal("reset row_open", 32'(row_open), 32'd0);
    checkVal("reset req_ready", 32'(req_ready), 32'd0);
    nRST = 1'b1;

    runTxn(1'b0, 16'h0012, 10'h005, 1'b0, 1'b0, 1'b0);
    runTxn(1'b0, 16'h0005, 10'h001, 1'b0, 1'b0, 1'b0);
    runTxn(1'b1, 16'h0005, 10'h3FF, 1'b0, 1'b0, 1'b0);
    runTxn(1'b0, 16'h0009, 10'h002, 1'b0, 1'b0, 1'b0);
    runTxn(1'b0, 16'h0007, 10'h003, 1'b1, 1'b0, 1'b0);
    runTxn(1'b0, 16'h0008, 10'h004, 1'b0, 1'b1, 1'b0);
    runTxn(1'b0, 16'h0008, 10'h006, 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      w   = 1'($urandom);
      pre = ($urandom_range(0, 7) == 0);
      mid = !pre && ($urandom_range(0, 5) == 0);
      rst = !pre && !mid && ($urandom_range(0, 9) == 0);
      runTxn(w, pickRow(), COL_W'($urandom), pre, mid, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
